// File: rtl/yarvi_pkg.sv
// rtl/yarvi_pkg.sv - shared constants for the yarvi byte buffers
//
// Purpose: default data width and depth for the RX (and future TX) byte
//          buffers, plus the pointer-width derivation they share.
// Ports:   none (package).
package yarvi_pkg;

    localparam int YARVI_WIDTH      = 8;
    localparam int YARVI_DEPTH_LOG2 = 4;

    // One extra pointer bit distinguishes full from empty when the
    // storage index bits are equal.
    function automatic int yarvi_ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/yarvi_fifo_mem.sv
// rtl/yarvi_fifo_mem.sv - register-array storage for the yarvi byte buffers
//
// Purpose: 2^ADDR_W x WIDTH register array, one synchronous write port and
//          one combinational read port. Storage is not reset.
// Ports:
//   i_clock  in   write clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational)
module yarvi_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/yarvi_rx_fifo.sv
// rtl/yarvi_rx_fifo.sv - first-word-fall-through byte receive buffer
//
// Purpose: absorbs receiver bursts ahead of the SoC rx_* port; exposes
//          occupancy and a sticky overflow flag.
// Build option: YARVI_RX_FIFO_DROP_EN - in_ready tied high, pushes while
//          full are discarded and set overflow. Undefined: backpressure via
//          in_ready, overflow tied 0, overflow_clear ignored.
// Ports:
//   clock           in   sole clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   in_valid        in   byte offered by receiver
//   in_data         in   offered byte
//   in_ready        out  byte accepted this cycle
//   out_valid       out  head byte available
//   out_data        out  head byte
//   out_ready       in   head consumed this cycle
//   count           out  occupancy 0..DEPTH
//   overflow        out  sticky byte-lost flag
//   overflow_clear  in   clears overflow (set wins)
module yarvi_rx_fifo
    import yarvi_pkg::*;
#(
    parameter int WIDTH      = YARVI_WIDTH,
    parameter int DEPTH_LOG2 = YARVI_DEPTH_LOG2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    input  logic                out_ready,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    input  logic                overflow_clear
);

    localparam int            PW      = yarvi_ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);

    // Push is gated by full in both builds, so a full FIFO never takes a
    // byte even when it pops in the same cycle (no pass-through).
    assign w_push = in_valid & ~w_full;
    assign w_pop  = ~w_empty & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    yarvi_fifo_mem #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .i_clock (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[PW-2:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[PW-2:0]),
        .o_rdata (out_data)
    );

    assign out_valid = ~w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;

`ifdef YARVI_RX_FIFO_DROP_EN
    logic r_overflow;
    logic w_drop;

    assign in_ready = 1'b1;
    assign w_drop   = in_valid & w_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_clear;

    assign in_ready       = ~w_full;
    assign overflow       = 1'b0;
    assign w_unused_clear = overflow_clear;
`endif

endmodule

// File: tb/tb_yarvi_rx_fifo.sv
// tb/tb_yarvi_rx_fifo.sv - self-checking bench for yarvi_rx_fifo
module tb_yarvi_rx_fifo;

    localparam int DEPTH = 16;

    logic       clock          = 1'b0;
    logic       reset_n        = 1'b0;
    logic       in_valid       = 1'b0;
    logic [7:0] in_data        = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready      = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clear = 1'b0;

    yarvi_rx_fifo dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock = ~clock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q[$];
    logic [7:0] got[$];
    bit         m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT to the queue model at the
    // falling edge, then advance the model across the rising edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit clr);
        bit do_push;
        bit do_pop;
        bit do_drop;
        in_valid       = v;
        in_data        = d;
        out_ready      = r;
        overflow_clear = clr;
        @(negedge clock);
        check("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        check("count", {27'd0, count}, q.size());
        if (q.size() != 0) check("data", {24'd0, out_data}, {24'd0, q[0]});
`ifdef YARVI_RX_FIFO_DROP_EN
        check("in_ready", {31'd0, in_ready}, 32'd1);
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`else
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
        check("overflow", {31'd0, overflow}, 32'd0);
`endif
        do_pop  = r && (q.size() != 0);
        do_push = v && (q.size() < DEPTH);
        do_drop = v && (q.size() == DEPTH);
        @(posedge clock);
        if (do_pop) got.push_back(q.pop_front());
        if (do_push) q.push_back(d);
        if (do_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    initial begin
        int pv;
        int pr;
        // Reset state, sampled while reset is still asserted.
        #12;
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Three pushes held, then drained in order.
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0);
        check("t1_count", {27'd0, count}, 32'd3);
        check("t1_head", {24'd0, out_data}, 32'h41);
        got.delete();
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_n", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("t1_b0", {24'd0, got[0]}, 32'h41);
            check("t1_b1", {24'd0, got[1]}, 32'h42);
            check("t1_b2", {24'd0, got[2]}, 32'h43);
        end
        check("t1_empty_cnt", {27'd0, count}, 32'd0);
        check("t1_empty_vld", {31'd0, out_valid}, 32'd0);

        // Fill to 16.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("t2_count", {27'd0, count}, 32'd16);
`ifdef YARVI_RX_FIFO_DROP_EN
        check("t2_ready", {31'd0, in_ready}, 32'd1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        check("t4_count", {27'd0, count}, 32'd16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_clr", {31'd0, overflow}, 32'd0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        check("t5_setwins", {31'd0, overflow}, 32'd1);
        got.delete();
        repeat (DEPTH) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_n", got.size(), DEPTH);
        if (got.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) check("t4_seq", {24'd0, got[i]}, i);
`else
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("t2_held", {27'd0, count}, 32'd16);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        check("t2_popcnt", {27'd0, count}, 32'd15);
        check("t2_reopen", {31'd0, in_ready}, 32'd1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("t2_refill", {27'd0, count}, 32'd16);
        got.delete();
        repeat (DEPTH) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_n", got.size(), DEPTH);
        if (got.size() == DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) check("t2_seq", {24'd0, got[i]}, i + 1);
            check("t2_last", {24'd0, got[DEPTH-1]}, 32'hFF);
        end
`endif

        // Streaming: one byte in and out per cycle, occupancy held at 1.
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            check("t3_count", {27'd0, count}, 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream.
        repeat (5) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("t6_pre", {27'd0, count}, 32'd5);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("t6_count", {27'd0, count}, 32'd0);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        got.delete();
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_first_n", got.size(), 32'd1);
        if (got.size() == 1) check("t6_first", {24'd0, got[0]}, 32'h5A);

        // Randomized traffic with shifting push/pop bias to visit full and empty.
        for (int blk = 0; blk < 8; blk++) begin
            pv = (blk % 2 == 0) ? 9 : 4;
            pr = (blk % 2 == 0) ? 3 : 9;
            repeat (300) begin
                cyc($urandom_range(0, 9) < pv, 8'($urandom), $urandom_range(0, 9) < pr,
                    $urandom_range(0, 15) == 0);
            end
        end
        repeat (DEPTH + 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("rnd_drained", {27'd0, count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
